clk_rate_gen: RTL and testbench

- Upstream neighbour of the switch-driven clock selector.
- Divides the single board clock into three 50%-duty square waves: clkFast, clkMedium and clkSlow. These feed the selector's three clock inputs.
- Provides an enable, used to freeze the board, and a synchronous phase-realign strobe so all three rates restart aligned.
- Pure sequential divider: three independent terminal-count counters, each driving a toggle flop.

---
 rtl/clk_rate_gen.sv | 99 +++++++++
 tb/tb_clk_rate_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clk_rate_gen.sv
// Board-clock divider producing three 50%-duty rates with enable and phase realign.
// Define CLK_RATE_TICK_EN to add single-cycle rising-edge tick outputs.
module clk_rate_gen #(
  parameter int FAST_HALF   = 2500000,
  parameter int MEDIUM_HALF = 12500000,
  parameter int SLOW_HALF   = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic clk,
  input  logic rstN,
  input  logic en,
  input  logic realign,
`ifdef CLK_RATE_TICK_EN
  output logic tickFast,
  output logic tickMedium,
  output logic tickSlow,
`endif
  output logic clkFast,
  output logic clkMedium,
  output logic clkSlow
);

  // A half-period of zero or one whose terminal count overflows CNT_W cannot be built.
  if (FAST_HALF < 1 || FAST_HALF > (1 << CNT_W)) begin : g_bad_fast
    $error("clk_rate_gen: FAST_HALF must be in 1..2**CNT_W");
  end
  if (MEDIUM_HALF < 1 || MEDIUM_HALF > (1 << CNT_W)) begin : g_bad_medium
    $error("clk_rate_gen: MEDIUM_HALF must be in 1..2**CNT_W");
  end
  if (SLOW_HALF < 1 || SLOW_HALF > (1 << CNT_W)) begin : g_bad_slow
    $error("clk_rate_gen: SLOW_HALF must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] FAST_TC   = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] MEDIUM_TC = CNT_W'(MEDIUM_HALF - 1);
  localparam logic [CNT_W-1:0] SLOW_TC   = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_fast_r;
  logic [CNT_W-1:0] cnt_medium_r;
  logic [CNT_W-1:0] cnt_slow_r;
  logic [2:0]       clk_r;
  logic [2:0]       tc_s;

  assign tc_s[0] = (cnt_fast_r   == FAST_TC);
  assign tc_s[1] = (cnt_medium_r == MEDIUM_TC);
  assign tc_s[2] = (cnt_slow_r   == SLOW_TC);

  // Terminal-count counters and toggle flops; realign outranks en.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_fast_r   <= '0;
      cnt_medium_r <= '0;
      cnt_slow_r   <= '0;
      clk_r        <= 3'b000;
    end else if (realign) begin
      cnt_fast_r   <= '0;
      cnt_medium_r <= '0;
      cnt_slow_r   <= '0;
      clk_r        <= 3'b000;
    end else if (en) begin
      cnt_fast_r   <= tc_s[0] ? '0 : cnt_fast_r   + CNT_ONE;
      cnt_medium_r <= tc_s[1] ? '0 : cnt_medium_r + CNT_ONE;
      cnt_slow_r   <= tc_s[2] ? '0 : cnt_slow_r   + CNT_ONE;
      clk_r        <= clk_r ^ tc_s;
    end else begin
      cnt_fast_r   <= cnt_fast_r;
      cnt_medium_r <= cnt_medium_r;
      cnt_slow_r   <= cnt_slow_r;
      clk_r        <= clk_r;
    end
  end

  assign clkFast   = clk_r[0];
  assign clkMedium = clk_r[1];
  assign clkSlow   = clk_r[2];

`ifdef CLK_RATE_TICK_EN
  logic [2:0] tick_r;

  // Tick fires on the same edge a divided clock toggles from low to high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tick_r <= 3'b000;
    end else if (realign) begin
      tick_r <= 3'b000;
    end else if (en) begin
      tick_r <= tc_s & ~clk_r;
    end else begin
      tick_r <= 3'b000;
    end
  end

  assign tickFast   = tick_r[0];
  assign tickMedium = tick_r[1];
  assign tickSlow   = tick_r[2];
`endif

endmodule

// File: tb/tb_clk_rate_gen.sv
// Self-checking bench for clk_rate_gen: vector table, random run against an
// arithmetic reference model, and an asynchronous mid-period reset.
module tb_clk_rate_gen;
  localparam int FH = 2;
  localparam int MH = 3;
  localparam int SH = 5;

  logic clk = 1'b0;
  logic rstN;
  logic en;
  logic realign;
  logic clkFast;
  logic clkMedium;
  logic clkSlow;
`ifdef CLK_RATE_TICK_EN
  logic tickFast;
  logic tickMedium;
  logic tickSlow;
`endif

  clk_rate_gen #(
    .FAST_HALF(FH), .MEDIUM_HALF(MH), .SLOW_HALF(SH), .CNT_W(4)
  ) dut (
    .clk(clk), .rstN(rstN), .en(en), .realign(realign),
`ifdef CLK_RATE_TICK_EN
    .tickFast(tickFast), .tickMedium(tickMedium), .tickSlow(tickSlow),
`endif
    .clkFast(clkFast), .clkMedium(clkMedium), .clkSlow(clkSlow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic       r;
    logic [2:0] exp; // {slow, medium, fast}
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;        // enabled edges since last reset/realign
  bit   last_en = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic r, input logic s, input logic m, input logic f);
    vec_t v;
    v.e = e; v.r = r; v.exp = {s, m, f};
    tbl.push_back(v);
  endtask

  // Apply inputs, take one edge, sample 1 time unit later, advance the model.
  task automatic step(input logic e, input logic r);
    en = e;
    realign = r;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) n++;
    last_en = e && !r;
  endtask

  function automatic logic rate_level(input int cnt, input int half);
    return ((cnt / half) % 2) == 1;
  endfunction

  function automatic logic rate_tick(input int cnt, input int half, input bit was_en);
    return was_en && cnt > 0 && (cnt % half) == 0 && ((cnt / half) % 2) == 1;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_fast"}, clkFast,   rate_level(n, FH));
    chk({tag, "_med"},  clkMedium, rate_level(n, MH));
    chk({tag, "_slow"}, clkSlow,   rate_level(n, SH));
`ifdef CLK_RATE_TICK_EN
    chk({tag, "_tickf"}, tickFast,   rate_tick(n, FH, last_en));
    chk({tag, "_tickm"}, tickMedium, rate_tick(n, MH, last_en));
    chk({tag, "_ticks"}, tickSlow,   rate_tick(n, SH, last_en));
`endif
  endtask

  initial begin
    // free run, edges 1..12: {slow, medium, fast}
    add(1,0, 0,0,0); add(1,0, 0,0,1); add(1,0, 0,1,1); add(1,0, 0,1,0);
    add(1,0, 1,1,0); add(1,0, 1,0,1); add(1,0, 1,0,1); add(1,0, 1,0,0);
    add(1,0, 1,1,0); add(1,0, 0,1,1); add(1,0, 0,1,1); add(1,0, 0,0,0);
    // realign, 3 enabled, 7 paused, then resume
    add(1,1, 0,0,0); add(1,0, 0,0,0); add(1,0, 0,0,1); add(1,0, 0,1,1);
    for (int i = 0; i < 7; i++) add(0,0, 0,1,1);
    add(1,0, 0,1,0); add(1,0, 1,1,0);
    // realign with en low still clears; counting restarts from zero
    add(0,1, 0,0,0); add(0,0, 0,0,0); add(0,0, 0,0,0);
    add(1,0, 0,0,0); add(1,0, 0,0,1); add(1,0, 0,1,1); add(1,0, 0,1,0);
    add(1,0, 1,1,0);

    rstN = 1'b0;
    en = 1'b1;
    realign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fast", clkFast, 1'b0);
    chk("reset_med",  clkMedium, 1'b0);
    chk("reset_slow", clkSlow, 1'b0);
`ifdef CLK_RATE_TICK_EN
    chk("reset_tickf", tickFast, 1'b0);
`endif
    @(negedge clk);
    rstN = 1'b1;
    n = 0;
    last_en = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].e, tbl[i].r);
      chk($sformatf("vec%0d_fast", i), clkFast,   tbl[i].exp[0]);
      chk($sformatf("vec%0d_med", i),  clkMedium, tbl[i].exp[1]);
      chk($sformatf("vec%0d_slow", i), clkSlow,   tbl[i].exp[2]);
`ifdef CLK_RATE_TICK_EN
      check_model($sformatf("vec%0d_model", i));
`endif
    end

    // randomized enable/realign against the arithmetic model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      check_model("rand");
    end

    // asynchronous reset while clkSlow is high
    step(1'b0, 1'b1);
    repeat (7) step(1'b1, 1'b0);
    chk("pre_rst_slow", clkSlow, 1'b1);
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_fast", clkFast, 1'b0);
    chk("async_rst_med",  clkMedium, 1'b0);
    chk("async_rst_slow", clkSlow, 1'b0);
    #2 rstN = 1'b1;
    n = 0;
    last_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("post_rst_slow%0d", i), clkSlow, i == 5);
    end
    check_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
